// File: rtl/cmos_rgb565_capture.sv
// DVP byte-stream capture: drops warm-up frames, packs byte pairs into RGB565
// pixels and frames them with sop/eop, pulsing frame_err on malformed input.
module cmos_rgb565_capture #(
    parameter int H_PIX       = 640,
    parameter int V_LINE      = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [15:0] dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        frame_err
);
    localparam int COL_W  = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int ROW_W  = (V_LINE > 1) ? $clog2(V_LINE) : 1;
    localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    localparam logic S_SKIP   = 1'b0;
    localparam logic S_ACTIVE = 1'b1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_PIX - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_LINE - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_FRAMES);

    logic       vs_r, vs_d, hr_r, hr_d;
    logic [7:0] data_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_r   <= 1'b0;
            vs_d   <= 1'b0;
            hr_r   <= 1'b0;
            hr_d   <= 1'b0;
            data_r <= '0;
        end else begin
            vs_r   <= cam_vsync;
            vs_d   <= vs_r;
            hr_r   <= cam_href;
            hr_d   <= hr_r;
            data_r <= cam_data;
        end
    end

    logic vs_rise, hr_fall;
    assign vs_rise = vs_r & ~vs_d;
    assign hr_fall = hr_d & ~hr_r;

    logic              state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              phase;
    logic [7:0]        hi_byte;
    // col/row saturate at their last index; these flags mark "one past the end"
    logic              line_full, row_full;
    logic              eop_done, frame_pix, short_seen, drop_seen;

    logic [15:0] pix;
    logic        pix_vld, pix_sop, pix_eop, pix_err;

    logic byte_en, pix_fire, pix_keep, pix_drop, line_used;
    logic at_sop, at_eop, line_err, trunc_err, drop_err;

    always_comb begin
        byte_en   = (state == S_ACTIVE) && hr_r && !vs_r;
        pix_fire  = byte_en && phase;
        pix_keep  = pix_fire && !line_full && !row_full;
        pix_drop  = pix_fire && !pix_keep;
        line_used = line_full || (col != '0);
        at_sop    = (row == '0) && (col == '0);
        at_eop    = (row == ROW_LAST) && (col == COL_LAST) && !short_seen;
        line_err  = (state == S_ACTIVE) && hr_fall && !vs_rise
                    && (phase || (line_used && !line_full));
        trunc_err = (state == S_ACTIVE) && vs_rise && !eop_done && frame_pix;
        drop_err  = pix_drop && !drop_seen;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_SKIP;
            skip_cnt   <= '0;
            col        <= '0;
            row        <= '0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            line_full  <= 1'b0;
            row_full   <= 1'b0;
            eop_done   <= 1'b0;
            frame_pix  <= 1'b0;
            short_seen <= 1'b0;
            drop_seen  <= 1'b0;
            pix        <= '0;
            pix_vld    <= 1'b0;
            pix_sop    <= 1'b0;
            pix_eop    <= 1'b0;
            pix_err    <= 1'b0;
        end else begin
            pix_vld <= pix_keep;
            pix_sop <= pix_keep && at_sop;
            pix_eop <= pix_keep && at_eop;
            pix_err <= line_err | trunc_err | drop_err;
            if (pix_keep) begin
                pix <= {hi_byte, data_r};
            end

            if (vs_rise) begin
                // a frame start overrides any line end on the same edge
                if (state == S_SKIP) begin
                    if (skip_cnt == SKIP_LAST) begin
                        state <= S_ACTIVE;
                    end else begin
                        skip_cnt <= skip_cnt + 1'b1;
                    end
                end
                col        <= '0;
                row        <= '0;
                phase      <= 1'b0;
                line_full  <= 1'b0;
                row_full   <= 1'b0;
                eop_done   <= 1'b0;
                frame_pix  <= 1'b0;
                short_seen <= 1'b0;
                drop_seen  <= 1'b0;
            end else if (state == S_ACTIVE) begin
                if (byte_en) begin
                    phase <= ~phase;
                    if (!phase) begin
                        hi_byte <= data_r;
                    end else if (pix_keep) begin
                        frame_pix <= 1'b1;
                        if (at_eop) begin
                            eop_done <= 1'b1;
                        end
                        if (col == COL_LAST) begin
                            line_full <= 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end else begin
                        drop_seen <= 1'b1;
                    end
                end else if (hr_fall) begin
                    if (line_used) begin
                        if (row == ROW_LAST) begin
                            row_full <= 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                        if (!line_full) begin
                            short_seen <= 1'b1;
                        end
                    end
                    col       <= '0;
                    line_full <= 1'b0;
                    phase     <= 1'b0;
                    drop_seen <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout      <= '0;
            dout_vld  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            dout      <= pix;
            dout_vld  <= pix_vld;
            dout_sop  <= pix_sop;
            dout_eop  <= pix_eop;
            frame_err <= pix_err;
        end
    end

endmodule
